// File: rtl/event_sim_pkg.sv
// Shared types and reference truth tables for the
// event-block stimulus/response checker.
package event_sim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } checker_state_t;

  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;

endpackage

// File: rtl/event_hold_timer.sv
// Loadable hold counter with a terminal-count pulse
// on the last enabled cycle of a HOLD_CYCLES window.
module event_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // count enabled cycles; clear restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/event_response_checker.sv
// Sweeps every input vector onto a small combinational
// block and checks its output against a truth table.
module event_response_checker
  import event_sim_pkg::*;
#(
  parameter int                N_IN        = 2,
  parameter int                HOLD_CYCLES = 1,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE = TT_AND,
  parameter int                ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_idx
);

  checker_state_t r_state;
  checker_state_t w_next;

  logic [N_IN-1:0]  r_stim;
  logic [ERR_W-1:0] r_err;
  logic             r_ffv;
  logic [N_IN-1:0]  r_ffi;
  logic             r_done;

  logic w_accept;
  logic w_last;
  logic w_exp;
  logic w_mis;
  logic w_clr;
  logic w_en;
  logic w_tc;

  assign w_accept = start &&
                    ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_stim == '1);
  assign w_exp    = TRUTH_TABLE[r_stim];
  assign w_mis    = (r_state == SAMPLE) && (resp != w_exp);

  event_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_tc  (w_tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state and hold-timer control
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = DRIVE;
          w_clr  = 1'b1;
        end
      end
      DRIVE: begin
        w_en = 1'b1;
        if (w_tc) begin
          w_next = SAMPLE;
        end
      end
      SAMPLE: begin
        w_clr  = 1'b1;
        w_next = w_last ? DONE : DRIVE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // stimulus stepping, error count and first-fail capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim <= '0;
      r_err  <= '0;
      r_ffv  <= 1'b0;
      r_ffi  <= '0;
    end else if (w_accept) begin
      r_stim <= '0;
      r_err  <= '0;
      r_ffv  <= 1'b0;
      r_ffi  <= '0;
    end else if (r_state == SAMPLE) begin
      if (w_mis) begin
        if (r_err != '1) begin
          r_err <= r_err + ERR_W'(1);
        end
        if (!r_ffv) begin
          r_ffv <= 1'b1;
          r_ffi <= r_stim;
        end
      end
      if (!w_last) begin
        r_stim <= r_stim + N_IN'(1);
      end
    end
  end

  // done rises one cycle after DONE is entered, drops on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE) && !start;
    end
  end

  assign stim             = r_stim;
  assign busy             = (r_state == DRIVE) ||
                            (r_state == SAMPLE);
  assign done             = r_done;
  assign pass             = r_done && (r_err == '0);
  assign err_count        = r_err;
  assign first_fail_valid = r_ffv;
  assign first_fail_idx   = r_ffi;

endmodule

// File: tb/tb_event_response_checker.sv
// Directed bench: sweep timing, mismatch counting,
// saturation, glitch tolerance, restart and reset.
module tb_event_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a: defaults, AND table, AND or XOR block
  logic       a_start = 1'b0;
  logic       a_xor = 1'b0;
  logic [1:0] a_stim;
  logic       a_resp;
  logic       a_busy, a_done, a_pass, a_ffv;
  logic [7:0] a_err;
  logic [1:0] a_ffi;

  assign a_resp = a_xor ? (a_stim[0] ^ a_stim[1])
                        : (a_stim[0] & a_stim[1]);

  event_response_checker u_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (a_start),
    .stim             (a_stim),
    .resp             (a_resp),
    .busy             (a_busy),
    .done             (a_done),
    .pass             (a_pass),
    .err_count        (a_err),
    .first_fail_valid (a_ffv),
    .first_fail_idx   (a_ffi)
  );

  // instance b: 3 inputs, 2-bit counter, all-ones table, resp 0
  logic       b_start = 1'b0;
  logic [2:0] b_stim;
  logic       b_resp;
  logic       b_busy, b_done, b_pass, b_ffv;
  logic [1:0] b_err;
  logic [2:0] b_ffi;

  assign b_resp = 1'b0;

  event_response_checker #(
    .N_IN        (3),
    .HOLD_CYCLES (1),
    .TRUTH_TABLE (8'hFF),
    .ERR_W       (2)
  ) u_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (b_start),
    .stim             (b_stim),
    .resp             (b_resp),
    .busy             (b_busy),
    .done             (b_done),
    .pass             (b_pass),
    .err_count        (b_err),
    .first_fail_valid (b_ffv),
    .first_fail_idx   (b_ffi)
  );

  // instance c: hold 3, AND block glitching wrong in hold cycles 1-2
  logic       c_start = 1'b0;
  logic [1:0] c_stim;
  logic       c_resp;
  logic       c_good;
  logic [1:0] c_phase = 2'd0;
  logic       c_busy, c_done, c_pass, c_ffv;
  logic [7:0] c_err;
  logic [1:0] c_ffi;

  always @(posedge clk) begin
    c_phase <= c_start ? 2'd0 : c_phase + 2'd1;
  end

  assign c_good = c_stim[0] & c_stim[1];
  assign c_resp = (c_phase < 2'd2) ? ~c_good : c_good;

  event_response_checker #(
    .HOLD_CYCLES (3)
  ) u_c (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (c_start),
    .stim             (c_stim),
    .resp             (c_resp),
    .busy             (c_busy),
    .done             (c_done),
    .pass             (c_pass),
    .err_count        (c_err),
    .first_fail_valid (c_ffv),
    .first_fail_idx   (c_ffi)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // reset state
    step(2);
    chk("rst_stim", 32'(a_stim), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_pass", 32'(a_pass), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_ffv", 32'(a_ffv), 0);
    chk("rst_ffi", 32'(a_ffi), 0);
    rst_n = 1'b1;
    step(1);

    // AND block, AND table: clean sweep, done 9 cycles after start
    pulse_a();
    for (int k = 0; k < 8; k++) begin
      chk("and_stim", 32'(a_stim), 32'(k / 2));
      chk("and_busy", 32'(a_busy), 1);
      chk("and_done_early", 32'(a_done), 0);
      step(1);
    end
    chk("and_done_c8", 32'(a_done), 0);
    chk("and_busy_c8", 32'(a_busy), 0);
    step(1);
    chk("and_done", 32'(a_done), 1);
    chk("and_pass", 32'(a_pass), 1);
    chk("and_err", 32'(a_err), 0);
    chk("and_ffv", 32'(a_ffv), 0);
    chk("and_stim_last", 32'(a_stim), 3);

    // XOR block against AND table: misses at 1,2,3
    a_xor = 1'b1;
    pulse_a();
    step(9);
    chk("xor_done", 32'(a_done), 1);
    chk("xor_err", 32'(a_err), 3);
    chk("xor_ffv", 32'(a_ffv), 1);
    chk("xor_ffi", 32'(a_ffi), 1);
    chk("xor_pass", 32'(a_pass), 0);

    // restart from DONE clears results; start while busy ignored
    a_xor = 1'b0;
    pulse_a();
    chk("rs_done_drop", 32'(a_done), 0);
    chk("rs_err_clr", 32'(a_err), 0);
    chk("rs_ffv_clr", 32'(a_ffv), 0);
    chk("rs_ffi_clr", 32'(a_ffi), 0);
    chk("rs_busy", 32'(a_busy), 1);
    chk("rs_stim0", 32'(a_stim), 0);
    step(4);
    pulse_a();
    chk("busy_start_stim", 32'(a_stim), 2);
    chk("busy_start_busy", 32'(a_busy), 1);
    step(3);
    chk("busy_start_c8", 32'(a_done), 0);
    step(1);
    chk("busy_start_done", 32'(a_done), 1);
    chk("busy_start_pass", 32'(a_pass), 1);

    // rerun from DONE gives identical results
    pulse_a();
    chk("rerun_done_drop", 32'(a_done), 0);
    step(9);
    chk("rerun_done", 32'(a_done), 1);
    chk("rerun_pass", 32'(a_pass), 1);
    chk("rerun_err", 32'(a_err), 0);
    chk("rerun_ffv", 32'(a_ffv), 0);

    // saturation: 8 misses into a 2-bit counter
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("sat_latency", 32'(cyc), 17);
    chk("sat_done", 32'(b_done), 1);
    chk("sat_err", 32'(b_err), 3);
    chk("sat_ffv", 32'(b_ffv), 1);
    chk("sat_ffi", 32'(b_ffi), 0);
    chk("sat_pass", 32'(b_pass), 0);

    // hold 3: early glitches are not sampled
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    cyc = 0;
    while (!c_done && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("hold_latency", 32'(cyc), 17);
    chk("hold_err", 32'(c_err), 0);
    chk("hold_ffv", 32'(c_ffv), 0);
    chk("hold_pass", 32'(c_pass), 1);

    // reset mid-DRIVE at stim=2 after one recorded miss
    a_xor = 1'b1;
    pulse_a();
    step(4);
    chk("mid_stim", 32'(a_stim), 2);
    chk("mid_err", 32'(a_err), 1);
    chk("mid_busy", 32'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_stim", 32'(a_stim), 0);
    chk("arst_busy", 32'(a_busy), 0);
    chk("arst_err", 32'(a_err), 0);
    chk("arst_ffv", 32'(a_ffv), 0);
    chk("arst_done", 32'(a_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("arst_idle", 32'(a_busy), 0);
    a_xor = 1'b0;
    pulse_a();
    chk("post_stim0", 32'(a_stim), 0);
    chk("post_busy", 32'(a_busy), 1);
    step(9);
    chk("post_done", 32'(a_done), 1);
    chk("post_pass", 32'(a_pass), 1);
    chk("post_err", 32'(a_err), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/event_response_checker.md
Name: event_response_checker

Overview:
Synthesizable self-checking stimulus/response engine for small combinational event blocks such as event_simulation.
- Drives every input combination onto the DUT inputs and holds each for a programmable settle time.
- Samples the DUT output at the end of each hold and compares it against a parameterised truth table.
- Reports pass/fail, a saturating error count and the first failing vector.

Parameters:
N_IN, 2, number of DUT inputs driven (1..8); stim[0]=a, stim[1]=b.
HOLD_CYCLES, 1, clock cycles each vector is held before sampling (>=1).
TRUTH_TABLE, 4'b1000, width 2**N_IN; bit i = expected resp when stim==i (default: AND).
ERR_W, 8, width of the error counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to run a full sweep
stim  output  N_IN  vector driven to DUT inputs
resp  input  1  DUT output under check
busy  output  1  sweep in progress
done  output  1  sweep complete; level, held until next accepted start
pass  output  1  done && err_count==0
err_count  output  ERR_W  mismatches in current/last sweep, saturating
first_fail_valid  output  1  at least one mismatch recorded
first_fail_idx  output  N_IN  stim value of first mismatch

Behaviour:
- One clock domain (clk); reset is asynchronous, active-low (rst_n). All outputs reset to 0; FSM reset state IDLE.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start=1: clear err_count, first_fail_valid, first_fail_idx and hold_cnt; set stim=0; go to DRIVE; done drops the next cycle.
- DRIVE: stim stable; hold_cnt increments each cycle; after HOLD_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE (1 cycle): compare resp with TRUTH_TABLE[stim].
  - On mismatch: err_count+1, saturating at all-ones.
  - On the first mismatch only: latch first_fail_idx=stim and set first_fail_valid.
  - If stim == 2**N_IN-1: go to DONE, stim held at last value. Otherwise stim+1, hold_cnt=0, go to DRIVE.
- DONE: done=1, pass=(err_count==0); holds until start.
- busy=1 in DRIVE and SAMPLE only.
- start while busy is ignored and has no effect on the sweep.
- Sweep latency from the accepted start edge to done=1: 2**N_IN*(HOLD_CYCLES+1)+1 cycles. Default: 4*2+1=9.
- stim changes only on the SAMPLE->DRIVE transition. resp is assumed combinationally derived from stim, settled within HOLD_CYCLES.
- rst_n asserted mid-sweep: immediate return to IDLE with all outputs 0. No partial results are retained.
- Widths: hold_cnt is clog2(HOLD_CYCLES+1) bits. The stim increment never wraps because the terminal check precedes it.

Decomposition:
- Shared package event_sim_pkg:
  - FSM state enum checker_state_t {IDLE, DRIVE, SAMPLE, DONE}.
  - Default TRUTH_TABLE constants for the event blocks: AND 4'b1000, OR 4'b1110, XOR 4'b0110.
- One natural sub-module, event_hold_timer: loadable hold_cnt with a terminal-count pulse, reusable by other sequencers.
- Compare/count logic stays inline.

Test Plan:
- Reset, then start with an AND DUT, defaults -> stim steps 0,1,2,3 every 2 cycles; done at cycle 9; pass=1; err_count=0; first_fail_valid=0.
- XOR DUT against the default AND table -> mismatches at stim=1,2,3; err_count=3; first_fail_idx=1; pass=0.
- ERR_W=2, N_IN=3, table all-ones, resp tied 0 -> err_count saturates at 3 (not 8 wrapping to 0); first_fail_idx=0.
- HOLD_CYCLES=3, resp glitches wrong in the first 2 hold cycles and correct in the last -> no error counted; done at 4*4+1=17 cycles.
- start pulsed at cycle 4 while busy, then again in DONE -> first pulse ignored; second clears counters, done drops next cycle, sweep reruns with identical results.
- rst_n low for 1 cycle mid-DRIVE at stim=2 -> outputs 0 immediately; FSM in IDLE; a new start runs a full sweep from stim=0.
